// File: rtl/score_hex_controller.sv
// Binary score to six-digit active-low 7-seg display, serial shift-add-3 BCD.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero.
module score_hex_controller #(
    parameter int WIDTH     = 20,
    parameter int MAX_SCORE = 999999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] score,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] HI_RST = SEG_BLANK;
`else
    localparam logic [6:0] HI_RST = SEG_ZERO;
`endif

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] pend_val;
    logic             pending;
    logic [23:0]      bcd;
    logic [23:0]      bcd_adj;
    logic [CW-1:0]    cnt;
    logic [41:0]      hex_nxt;
    logic             lead;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        return (v > WIDTH'(MAX_SCORE)) ? WIDTH'(MAX_SCORE) : v;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign busy = (state != IDLE);

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Encode the finished BCD digits, optionally blanking leading zeros.
    always_comb begin
        hex_nxt = '0;
        lead    = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            hex_nxt[7*i +: 7] = seg(bcd[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && i > 0 && bcd[4*i +: 4] == 4'd0)
                hex_nxt[7*i +: 7] = SEG_BLANK;
            else
                lead = 1'b0;
`else
            lead = 1'b0;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: a load during UPDATE or a pending value restarts at once.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONVERT;
            CONVERT: if (cnt == CW'(WIDTH - 1)) state_nxt = UPDATE;
            UPDATE:  state_nxt = (load || pending) ? CONVERT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath, pending capture and display registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            pend_val <= '0;
            done     <= 1'b0;
            HEX0     <= SEG_ZERO;
            {HEX5, HEX4, HEX3, HEX2, HEX1} <= {5{HI_RST}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin <= clamp(score);
                        bcd <= '0;
                        cnt <= '0;
                    end
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
                    cnt        <= cnt + 1'b1;
                    if (load) begin
                        pending  <= 1'b1;
                        pend_val <= score;
                    end
                end
                UPDATE: begin
                    {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= hex_nxt;
                    done    <= 1'b1;
                    bin     <= load ? clamp(score) : clamp(pend_val);
                    bcd     <= '0;
                    cnt     <= '0;
                    pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_hex_controller.sv
// Randomized self-checking bench for score_hex_controller.
// Reference model derives digits with decimal arithmetic on the clamped score.
module tb_score_hex_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] score;
    logic        load;
    logic        busy;
    logic        done;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                 7'b0110000, 7'b0011001, 7'b0010010,
                                 7'b0000010, 7'b1111000, 7'b0000000,
                                 7'b0010000};

    score_hex_controller dut (
        .clk(clk), .reset_n(reset_n), .score(score), .load(load),
        .busy(busy), .done(done),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] hexv();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    function automatic logic [41:0] exp_hex(input int v);
        int c;
        int dig [6];
        bit lead;
        logic [41:0] r;
        c = (v > 999999) ? 999999 : v;
        for (int i = 0; i < 6; i++) begin
            dig[i] = c % 10;
            c = c / 10;
        end
        lead = 1'b1;
        r = '0;
        for (int i = 5; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && i > 0 && dig[i] == 0) begin
                r[7*i +: 7] = 7'b1111111;
                continue;
            end
`endif
            lead = 1'b0;
            r[7*i +: 7] = seg_tab[dig[i]];
        end
        return r;
    endfunction

    function automatic logic [41:0] rst_hex();
`ifdef LEADING_ZERO_BLANK_EN
        return {{5{7'b1111111}}, 7'b1000000};
`else
        return {6{7'b1000000}};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_conv(input int s);
        int n;
        int bcnt;
        bit got;
        score = 20'(s);
        load  = 1'b1;
        step();
        load  = 1'b0;
        bcnt  = busy ? 1 : 0;
        n     = 0;
        got   = 1'b0;
        while (n < 60 && !got) begin
            step();
            n++;
            if (done) got = 1'b1;
            else if (busy) bcnt++;
        end
        check("latency", 64'(n), 64'd21);
        check("busy_cycles", 64'(bcnt), 64'd21);
        check($sformatf("hex_%0d", s), 64'(hexv()), 64'(exp_hex(s)));
        check("busy_after", 64'(busy), 64'd0);
        step();
        check("done_single", 64'(done), 64'd0);
    endtask

    initial begin
        int s;
        int n;
        int ndone;
        logic [41:0] shown [2];

        reset_n = 1'b0;
        load    = 1'b0;
        score   = '0;
        step();
        step();
        check("rst_hex_asserted", 64'(hexv()), 64'(rst_hex()));
        reset_n = 1'b1;
        repeat (5) step();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_hex", 64'(hexv()), 64'(rst_hex()));

        do_conv(123456);
        do_conv(1048575);
        do_conv(42);
        do_conv(0);
        do_conv(999999);
        do_conv(1000000);
        do_conv(100000);
        for (int k = 0; k < 10; k++) begin
            s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 999))
                                            : int'($urandom_range(0, 1048575));
            do_conv(s);
        end

        // Newest load wins while busy; 55 must never appear.
        score = 20'd7;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (3) step();
        score = 20'd55;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (3) step();
        score = 20'd99;
        load  = 1'b1;
        step();
        load  = 1'b0;
        ndone = 0;
        shown[0] = '0;
        shown[1] = '0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (done) begin
                if (ndone < 2) shown[ndone] = hexv();
                ndone++;
            end
        end
        check("pend_done_count", 64'(ndone), 64'd2);
        check("pend_first_7", 64'(shown[0]), 64'(exp_hex(7)));
        check("pend_second_99", 64'(shown[1]), 64'(exp_hex(99)));

        // Load on the UPDATE edge restarts immediately.
        score = 20'd5;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (20) step();
        score = 20'd314159;
        load  = 1'b1;
        step();
        load  = 1'b0;
        check("upd_done", 64'(done), 64'd1);
        check("upd_hex_5", 64'(hexv()), 64'(exp_hex(5)));
        check("upd_busy", 64'(busy), 64'd1);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < 60);
        check("upd_restart_latency", 64'(n), 64'd21);
        check("upd_hex_314159", 64'(hexv()), 64'(exp_hex(314159)));
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (done) ndone++;
        end
        check("upd_no_extra_done", 64'(ndone), 64'd0);

        // Reset mid-conversion discards work and the pending value.
        score = 20'd999999;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (4) step();
        score = 20'd77;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        check("mid_rst_hex", 64'(hexv()), 64'(rst_hex()));
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (done || busy) ndone++;
        end
        check("mid_rst_quiet", 64'(ndone), 64'd0);
        check("mid_rst_hex_held", 64'(hexv()), 64'(rst_hex()));

        do_conv(8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
